max_pooling_fprop1_mul_pipe_hs: RTL and testbench

//  Parametrised pipelined multiplier with valid/ready handshake for the max_pooling_fprop1 datapath.

---
 rtl/max_pooling_fprop1_mul_pipe_hs_pkg.sv | 19 +
 rtl/max_pooling_fprop1_skid_buf.sv | 81 ++++++++
 rtl/max_pooling_fprop1_mul_pipe_hs.sv | 129 ++++++++++++
 tb/tb_max_pooling_fprop1_mul_pipe_hs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pooling_fprop1_mul_pipe_hs_pkg.sv
// ============================================================================
// max_pooling_fprop1_mul_pipe_hs_pkg : shared types for the handshake multiplier
// Revision 1.0
// ============================================================================
`default_nettype none

package max_pooling_fprop1_mul_pipe_hs_pkg;

   localparam int c_max_stage = 8;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/max_pooling_fprop1_skid_buf.sv
// ============================================================================
// max_pooling_fprop1_skid_buf : 2-entry input skid buffer with registered ready
// Revision 1.0
// ============================================================================
`default_nettype none

module max_pooling_fprop1_skid_buf
   import max_pooling_fprop1_mul_pipe_hs_pkg::*;
#(
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             in_ready_o,
   input  logic             en_i,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o
);

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             in_ready_q;
   logic             w_accept;

   assign w_accept    = in_valid_i && in_ready_q;
   assign in_ready_o  = in_ready_q;
   // Empty buffer passes the incoming pair straight through to stage 1.
   assign out_valid_o = (state_q != SKID_EMPTY) || w_accept;
   assign out_data_o  = (state_q != SKID_EMPTY) ? head_q : in_data_i;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      unique case (state_q)
         SKID_EMPTY: begin
            if (w_accept && !en_i) begin
               head_d  = in_data_i;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (w_accept && en_i) begin
               head_d = in_data_i;
            end else if (w_accept) begin
               tail_d  = in_data_i;
               state_d = SKID_FULL;
            end else if (en_i) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (en_i) begin
               head_d  = tail_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= SKID_EMPTY;
         in_ready_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != SKID_FULL);
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/max_pooling_fprop1_mul_pipe_hs.sv
// ============================================================================
// max_pooling_fprop1_mul_pipe_hs : pipelined valid/ready multiplier, truncate or saturate
// Revision 1.0
// ============================================================================
`default_nettype none

module max_pooling_fprop1_mul_pipe_hs
   import max_pooling_fprop1_mul_pipe_hs_pkg::*;
#(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 17,
   parameter int din1_WIDTH = 17,
   parameter int dout_WIDTH = 17,
   parameter int SIGNED     = 1,
   parameter int SATURATE   = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  out_ovf
);

   localparam int c_prod_w = din0_WIDTH + din1_WIDTH;

   logic                  w_en;
   logic                  w_skid_valid;
   logic [c_prod_w-1:0]   w_skid_data;
   logic [din0_WIDTH-1:0] w_op0;
   logic [din1_WIDTH-1:0] w_op1;
   logic [c_prod_w-1:0]   w_ext0, w_ext1, w_prod, w_p;
   logic [c_prod_w-1:0]   w_psrc [NUM_STAGE];
   logic [NUM_STAGE-1:0]  w_vsrc;
   logic [dout_WIDTH-1:0] w_dout_d, dout_q;
   logic                  w_ovf_d, ovf_q, valid_q;

   if (NUM_STAGE < 1 || NUM_STAGE > c_max_stage || dout_WIDTH < 1 ||
       dout_WIDTH > c_prod_w || ID < 0) begin : g_bad_param
      $error("max_pooling_fprop1_mul_pipe_hs: illegal parameter set");
   end

   // Global stall: every stage holds while the result is not taken.
   assign w_en      = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign dout      = dout_q;
   assign out_ovf   = ovf_q;

   max_pooling_fprop1_skid_buf #(
      .WIDTH (c_prod_w)
   ) u_skid (
      .clk         (ap_clk),
      .rst_n       (ap_rst_n),
      .in_valid_i  (in_valid),
      .in_data_i   ({din0, din1}),
      .in_ready_o  (in_ready),
      .en_i        (w_en),
      .out_valid_o (w_skid_valid),
      .out_data_o  (w_skid_data)
   );

   assign w_op0  = w_skid_data[c_prod_w-1 -: din0_WIDTH];
   assign w_op1  = w_skid_data[din1_WIDTH-1:0];
   // Extended to the full product width, the low bits of the product are exact.
   assign w_ext0 = {{din1_WIDTH{(SIGNED != 0) && w_op0[din0_WIDTH-1]}}, w_op0};
   assign w_ext1 = {{din0_WIDTH{(SIGNED != 0) && w_op1[din1_WIDTH-1]}}, w_op1};
   assign w_prod = w_ext0 * w_ext1;

   assign w_psrc[0] = w_prod;
   assign w_vsrc[0] = w_skid_valid;

   for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
      if (i < NUM_STAGE - 1) begin : g_mid
         logic [c_prod_w-1:0] p_q;
         logic                v_q;
         always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
               v_q <= 1'b0;
               p_q <= '0;
            end else if (w_en) begin
               v_q <= w_vsrc[i];
               p_q <= w_psrc[i];
            end
         end
         assign w_psrc[i+1] = p_q;
         assign w_vsrc[i+1] = v_q;
      end else begin : g_last
         assign w_p = w_psrc[i];
         always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
               valid_q <= 1'b0;
               dout_q  <= '0;
               ovf_q   <= 1'b0;
            end else if (w_en) begin
               valid_q <= w_vsrc[i];
               dout_q  <= w_dout_d;
               ovf_q   <= w_ovf_d;
            end
         end
      end
   end

   if (dout_WIDTH == c_prod_w) begin : g_noclamp
      assign w_ovf_d  = 1'b0;
      assign w_dout_d = w_p;
   end else begin : g_clamp
      localparam logic [dout_WIDTH-1:0] c_one = dout_WIDTH'(1);
      localparam logic [dout_WIDTH-1:0] c_min = (SIGNED != 0) ? (c_one << (dout_WIDTH - 1)) : '0;
      localparam logic [dout_WIDTH-1:0] c_max = ~c_min;
      logic w_neg;
      if (SIGNED != 0) begin : g_signed
         // Representable only when all bits above the result sign agree.
         assign w_ovf_d = !((&w_p[c_prod_w-1:dout_WIDTH-1]) || !(|w_p[c_prod_w-1:dout_WIDTH-1]));
      end else begin : g_unsigned
         assign w_ovf_d = |w_p[c_prod_w-1:dout_WIDTH];
      end
      assign w_neg    = (SIGNED != 0) && w_p[c_prod_w-1];
      assign w_dout_d = ((SATURATE != 0) && w_ovf_d) ? (w_neg ? c_min : c_max)
                                                     : w_p[dout_WIDTH-1:0];
   end

endmodule

`default_nettype wire

// File: tb/tb_max_pooling_fprop1_mul_pipe_hs.sv
// ============================================================================
// tb_max_pooling_fprop1_mul_pipe_hs : bench for truncating, signed-saturating and unsigned-saturating builds
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_max_pooling_fprop1_mul_pipe_hs;

   localparam int DW = 17;
   localparam int NS = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          out_ready;
   logic [DW-1:0] a, b;
   logic [2:0]    ir, ov, of;
   logic [DW-1:0] d      [3];
   logic [DW-1:0] prev_d [3];
   logic [DW-1:0] last_d [3];
   logic [2:0]    last_of;

   int n_cmp = 0, n_fail = 0, cyc = 0, n_acc = 0, n_out = 0;
   int acc_cyc = 0, out_cyc = 0;
   bit got_acc, got_out, stall_prev;
   logic [2*DW-1:0] q[$];

   // Per-instance configuration: {signed, saturate}
   bit cfg_sgn [3] = '{1'b1, 1'b1, 1'b0};
   bit cfg_sat [3] = '{1'b0, 1'b1, 1'b1};

   always #5 clk = ~clk;

   max_pooling_fprop1_mul_pipe_hs u_trunc (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .din0(a), .din1(b), .out_valid(ov[0]), .out_ready(out_ready),
      .dout(d[0]), .out_ovf(of[0]));

   max_pooling_fprop1_mul_pipe_hs #(.SATURATE(1)) u_ssat (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .din0(a), .din1(b), .out_valid(ov[1]), .out_ready(out_ready),
      .dout(d[1]), .out_ovf(of[1]));

   max_pooling_fprop1_mul_pipe_hs #(.SIGNED(0), .SATURATE(1)) u_usat (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .din0(a), .din1(b), .out_valid(ov[2]), .out_ready(out_ready),
      .dout(d[2]), .out_ovf(of[2]));

   // Reference: exact integer product, then range check and optional clamp.
   function automatic logic [DW:0] ref_mul(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input bit sgn, input bit sat);
      longint px, py, p, mn, mx;
      logic ovf;
      logic [DW-1:0] r;
      px  = sgn ? longint'($signed(x)) : longint'(x);
      py  = sgn ? longint'($signed(y)) : longint'(y);
      p   = px * py;
      mn  = sgn ? -(longint'(1) << (DW - 1)) : 0;
      mx  = sgn ? (longint'(1) << (DW - 1)) - 1 : (longint'(1) << DW) - 1;
      ovf = (p < mn) || (p > mx);
      if (sat && ovf) r = (p < 0) ? mn[DW-1:0] : mx[DW-1:0];
      else            r = p[DW-1:0];
      return {ovf, r};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: observe at the falling edge, then advance past the rising edge.
   task automatic cycle();
      logic [2*DW-1:0] e;
      logic [DW:0]     r;
      @(negedge clk);
      cyc++;
      got_acc = 1'b0;
      got_out = 1'b0;
      for (int k = 1; k < 3; k++) begin
         check($sformatf("valid_agree%0d", k), ov[k], ov[0]);
         check($sformatf("ready_agree%0d", k), ir[k], ir[0]);
      end
      if (stall_prev) begin
         check("hold_valid", ov[0], 1);
         for (int k = 0; k < 3; k++) check($sformatf("hold_dout%0d", k), d[k], prev_d[k]);
      end
      check("occupancy_bound", q.size() <= NS + 2, 1);
      if (ov[0] && out_ready) begin
         check("out_has_input", q.size() != 0, 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            for (int k = 0; k < 3; k++) begin
               r = ref_mul(e[2*DW-1:DW], e[DW-1:0], cfg_sgn[k], cfg_sat[k]);
               check($sformatf("dout%0d", k), d[k], r[DW-1:0]);
               check($sformatf("ovf%0d", k), of[k], r[DW]);
            end
         end
         for (int k = 0; k < 3; k++) begin
            last_d[k]  = d[k];
            last_of[k] = of[k];
         end
         got_out = 1'b1;
         out_cyc = cyc;
         n_out++;
      end
      if (in_valid && ir[0]) begin
         q.push_back({a, b});
         got_acc = 1'b1;
         acc_cyc = cyc;
         n_acc++;
      end
      stall_prev = ov[0] && !out_ready;
      prev_d     = d;
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input logic [DW-1:0] x, input logic [DW-1:0] y);
      bit done;
      a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (got_acc) begin done = 1'b1; break; end
      end
      in_valid = 1'b0;
      check("run_one_accept", done, 1);
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (got_out) begin done = 1'b1; break; end
      end
      check("run_one_out", done, 1);
      check("run_one_latency", out_cyc - acc_cyc, NS);
   endtask

   task automatic drain();
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 30 && q.size() != 0; i++) cycle();
      check("drain_empty", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, n0, first, last;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; stall_prev = 1'b0;
      repeat (3) cycle();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_in_ready%0d", i), ir[i], 0);
         check($sformatf("rst_out_valid%0d", i), ov[i], 0);
         check($sformatf("rst_dout%0d", i), d[i], 0);
         check($sformatf("rst_ovf%0d", i), of[i], 0);
      end

      // Reset release and first-result latency: -3 x 5
      rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; a = 17'h1FFFD; b = 17'd5;
      cycle();
      check("ready_after_release", ir[0], 1);
      cycle();
      check("first_accept", got_acc, 1);
      in_valid = 1'b0;
      check("latency_early", ov[0], 0);
      cycle();
      check("latency_valid", ov[0], 1);
      check("neg3x5_dout", d[0], 17'h1FFF1);
      check("neg3x5_ovf", of[0], 0);
      cycle();

      // Truncate / saturate corner values
      run_one(17'd300, 17'd300);
      check("300x300_trunc", last_d[0], 17'h15F90);  check("300x300_trunc_ovf", last_of[0], 1);
      check("300x300_ssat", last_d[1], 17'h0FFFF);   check("300x300_ssat_ovf", last_of[1], 1);
      check("300x300_usat", last_d[2], 17'h15F90);   check("300x300_usat_ovf", last_of[2], 0);
      run_one(17'h1FED4, 17'd300);
      check("m300x300_trunc", last_d[0], 17'h0A070); check("m300x300_trunc_ovf", last_of[0], 1);
      check("m300x300_ssat", last_d[1], 17'h10000);  check("m300x300_ssat_ovf", last_of[1], 1);
      check("m300x300_usat", last_d[2], 17'h1FFFF);  check("m300x300_usat_ovf", last_of[2], 1);
      run_one(17'h1FFFF, 17'd2);
      check("max_x2_usat", last_d[2], 17'h1FFFF);    check("max_x2_usat_ovf", last_of[2], 1);
      check("max_x2_ssat", last_d[1], 17'h1FFFE);    check("max_x2_ssat_ovf", last_of[1], 0);

      // Back-pressure: stream k x 7, stall once the pipe is flowing
      k = 0; a = 17'(k); b = 17'd7; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (got_acc) begin k++; a = 17'(k); end
      end
      out_ready = 1'b0;
      n0 = n_acc;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (got_acc) begin k++; a = 17'(k); end
      end
      check("stall_extra_accepts", n_acc - n0, 2);
      check("stall_ready_low", ir[0], 0);
      check("stall_occupancy", q.size(), NS + 2);
      for (int i = 0; i < 300 && k < 20; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'($urandom_range(1, 0));
         cycle();
         if (got_acc) begin k++; a = 17'(k); end
      end
      check("stream_all_accepted", k, 20);
      drain();

      // Throughput: 100 back-to-back transfers
      n0 = n_out; first = -1; last = -1;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 100 + NS + 2; i++) begin
         in_valid = (i < 100);
         a = 17'($urandom); b = 17'($urandom);
         cycle();
         if (got_out) begin
            if (first < 0) first = out_cyc;
            last = out_cyc;
         end
      end
      check("thru_count", n_out - n0, 100);
      check("thru_no_gaps", last - first, 99);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(9, 0) < 7);
         out_ready = ($urandom_range(9, 0) < 6);
         a = 17'($urandom); b = 17'($urandom);
         cycle();
      end
      drain();

      // Reset with the pipe and skid full
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10 && ir[0]; i++) begin
         a = 17'($urandom); b = 17'($urandom);
         cycle();
      end
      check("prefill_full", ir[0], 0);
      check("prefill_valid", ov[0], 1);
      rst_n = 1'b0; in_valid = 1'b0;
      cycle();
      q.delete();
      stall_prev = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("midrst_valid%0d", i), ov[i], 0);
         check($sformatf("midrst_ready%0d", i), ir[i], 0);
      end
      rst_n = 1'b1; out_ready = 1'b1;
      n0 = n_out;
      repeat (6) cycle();
      check("midrst_no_ghost", n_out - n0, 0);
      run_one(17'd2, 17'd2);
      check("post_rst_dout", last_d[0], 17'h00004);
      check("post_rst_ovf", last_of[0], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
